// File: rtl/column_spawner_pkg.sv
// ============================================================================
// Module : column_spawner_pkg
// Brief  : Shared constants and state encoding for the column light spawner.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package column_spawner_pkg;

  // x^10 + x^7 + 1, Fibonacci form shifting toward the MSB
  localparam int c_lfsr_tap_hi = 9;
  localparam int c_lfsr_tap_lo = 6;
  localparam int c_note_cnt_w  = 8;
  localparam int c_gap_w       = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/column_spawner_if.sv
// ============================================================================
// Module : column_spawner_if
// Brief  : Control/status bundle of one column spawner. Seed-load signals
//          exist only when COLUMN_SPAWNER_SEED_LOAD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface column_spawner_if #(
  parameter int DIV_W = 8
`ifdef COLUMN_SPAWNER_SEED_LOAD_EN
  , parameter int LFSR_W = 10
`endif
);

  logic                                   enable;
  logic [DIV_W-1:0]                       rate;
  logic [3:0]                             density;
  logic                                   step;
  logic                                   spawn;
  logic [column_spawner_pkg::c_note_cnt_w-1:0] note_cnt;
  logic                                   busy;

`ifdef COLUMN_SPAWNER_SEED_LOAD_EN
  logic                                   seed_load;
  logic [LFSR_W-1:0]                      seed_val;

  modport master (output enable, rate, density, seed_load, seed_val,
                  input  step, spawn, note_cnt, busy);
  modport slave  (input  enable, rate, density, seed_load, seed_val,
                  output step, spawn, note_cnt, busy);
`else
  modport master (output enable, rate, density,
                  input  step, spawn, note_cnt, busy);
  modport slave  (input  enable, rate, density,
                  output step, spawn, note_cnt, busy);
`endif

endinterface

`default_nettype wire

// File: rtl/column_spawner_step_divider.sv
// ============================================================================
// Module : step_divider
// Brief  : Programmable clock divider producing a one-cycle step pulse every
//          RATE+1 clocks while enabled; cleared whenever enable is low.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_divider #(
  parameter int DIV_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_enable,
  input  wire logic [DIV_W-1:0] i_rate,
  output logic                  o_step
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_step;

  // >= compare so a rate lowered below the running count fires immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (!i_enable) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (r_cnt >= i_rate) begin
      r_cnt  <= '0;
      r_step <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_step <= 1'b0;
    end
  end

  assign o_step = r_step;

endmodule

`default_nettype wire

// File: rtl/column_spawner.sv
// ============================================================================
// Module : column_spawner
// Brief  : Per-column note generator: LFSR pattern vs. density threshold,
//          step-rate divider and enforced cooldown gap after each note.
//          Optional LFSR reload via COLUMN_SPAWNER_SEED_LOAD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_spawner
  import column_spawner_pkg::*;
#(
  parameter int                LFSR_W  = 10,
  parameter logic [LFSR_W-1:0] SEED    = 10'h1A5,
  parameter int                DIV_W   = 8,
  parameter int                MIN_GAP = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  column_spawner_if.slave   bus
);

  localparam logic [LFSR_W-1:0]  c_seed    = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [c_gap_w-1:0] c_min_gap = c_gap_w'(MIN_GAP);

  state_t                    r_state, w_state_nx;
  logic [c_gap_w-1:0]        r_gap, w_gap_nx;
  logic                      r_spawn, w_spawn_nx;
  logic [c_note_cnt_w-1:0]   r_note_cnt, w_note_cnt_nx;
  logic [LFSR_W-1:0]         r_lfsr, w_lfsr_nx, w_lfsr_adv;
  logic                      w_step, w_fire, w_hit;

  step_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (bus.enable),
    .i_rate   (bus.rate),
    .o_step   (w_step)
  );

  assign w_lfsr_adv = {r_lfsr[LFSR_W-2:0], r_lfsr[c_lfsr_tap_hi] ^ r_lfsr[c_lfsr_tap_lo]};
  assign w_fire     = w_step & bus.enable;
  assign w_hit      = bus.density[3] | (r_lfsr[2:0] < bus.density[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_spawn    <= 1'b0;
      r_note_cnt <= '0;
      r_lfsr     <= c_seed;
    end else begin
      r_state    <= w_state_nx;
      r_gap      <= w_gap_nx;
      r_spawn    <= w_spawn_nx;
      r_note_cnt <= w_note_cnt_nx;
      r_lfsr     <= w_lfsr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_gap_nx      = r_gap;
    w_spawn_nx    = r_spawn;
    w_note_cnt_nx = r_note_cnt;
    w_lfsr_nx     = r_lfsr;
`ifdef COLUMN_SPAWNER_SEED_LOAD_EN
    if (bus.seed_load) begin
      w_lfsr_nx  = (bus.seed_val == '0) ? LFSR_W'(1) : bus.seed_val;
      w_gap_nx   = '0;
      w_spawn_nx = 1'b0;
      w_state_nx = bus.enable ? S_RUN : S_IDLE;
    end else
`endif
    if (!bus.enable) begin
      // pause discards any pending cooldown
      w_state_nx = S_IDLE;
      w_spawn_nx = 1'b0;
      w_gap_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_RUN;
        S_RUN: begin
          if (w_fire) begin
            w_lfsr_nx  = w_lfsr_adv;
            w_spawn_nx = w_hit;
            if (w_hit) begin
              if (r_note_cnt != '1) w_note_cnt_nx = r_note_cnt + 8'd1;
              if (c_min_gap != '0) begin
                w_gap_nx   = c_min_gap;
                w_state_nx = S_COOLDOWN;
              end
            end
          end
        end
        S_COOLDOWN: begin
          if (w_fire) begin
            w_lfsr_nx  = w_lfsr_adv;
            w_spawn_nx = 1'b0;
            if (r_gap <= c_gap_w'(1)) begin
              w_gap_nx   = '0;
              w_state_nx = S_RUN;
            end else begin
              w_gap_nx = r_gap - c_gap_w'(1);
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign bus.step     = w_step;
  assign bus.spawn    = r_spawn;
  assign bus.note_cnt = r_note_cnt;
  assign bus.busy     = (r_state == S_COOLDOWN);

endmodule

`default_nettype wire

// File: doc/column_spawner.md
Name: column_spawner

Overview:
- Producer end of the per-column light stream: decides when a new light enters the top row of a column and generates the row-advance tick that the row light chain and miss detector consume.
- Pseudo-random note pattern from an LFSR, density threshold, programmable step rate and an enforced minimum gap between notes.
- One instance per column; the bottom of the same chain feeds the miss logic.

Parameters:
- LFSR_W, 10, LFSR width; feedback polynomial fixed x^10+x^7+1 (maximal length).
- SEED, 10'h1A5, LFSR reset value; a value of 0 is replaced by 1 at reset.
- DIV_W, 8, width of RATE and of the step divider counter.
- MIN_GAP, 2, forced empty steps after every spawned note (0 allowed; 1..15).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run pattern; low = idle/paused.
- RATE  in  DIV_W  clocks per step minus 1.
- DENSITY  in  4  spawn threshold; 0 = never, >=8 = whenever gap allows.
- STEP  out  1  one-cycle pulse; row chain advances on it.
- SPAWN  out  1  level; light into top row, valid from one STEP to the next.
- NOTE_CNT  out  8  saturating count of spawned notes.
- BUSY  out  1  high while in COOLDOWN.

Behaviour:
- Reset (RESET=0, async): STEP=0, SPAWN=0, NOTE_CNT=0, BUSY=0, divider=0, gap=0, LFSR=SEED (or 1), state IDLE.
- Divider: counts 0..RATE while ENABLE=1; STEP=1 in the cycle counter>=RATE, counter returns to 0 next cycle. RATE=0 -> STEP every clock. RATE lowered below the current count -> STEP on the next cycle (>= compare), no stall.
- First STEP after ENABLE rises arrives RATE+1 clocks later.
- LFSR advances only on STEP, so the pattern is deterministic per step, independent of RATE.
- States:
  - IDLE: ENABLE=0; divider held at 0, SPAWN=0, LFSR and NOTE_CNT hold. ENABLE=1 -> RUN.
  - RUN: on STEP, if LFSR[2:0] < DENSITY (DENSITY>=8 always true) -> SPAWN<=1, NOTE_CNT+1 (saturate 255), gap<=MIN_GAP, go COOLDOWN (stay RUN if MIN_GAP=0); else SPAWN<=0.
  - COOLDOWN: on each STEP, SPAWN<=0, gap-1; when gap reaches 0 on that STEP -> RUN (next STEP eligible). BUSY=1.
- SPAWN registered, updates one cycle after the STEP-qualified clock edge, i.e. coincident with the row chain's sampling on the following STEP.
- ENABLE falls mid-operation -> next cycle IDLE: SPAWN=0, gap cleared, divider cleared; in-flight pattern discarded.
- ENABLE and STEP in the same cycle: ENABLE=0 wins, no spawn.
- DENSITY/RATE sampled live; changes apply at the next STEP.

Optional Feature:
- Macro COLUMN_SPAWNER_SEED_LOAD_EN.
- With it: extra inputs SEED_LOAD (1) and SEED_VAL (LFSR_W). SEED_LOAD=1 for one cycle loads the LFSR (0 -> 1) and clears gap/state to RUN (or IDLE if ENABLE=0); it has priority over STEP in the same cycle.
- Without it: those ports are absent; the LFSR is only set by reset.

Decomposition:
- Shared package: LFSR polynomial tap constants, state encoding (IDLE/RUN/COOLDOWN), NOTE_CNT width.
- One sub-module: step_divider (counter + STEP pulse, ENABLE clear), reused by other columns and the song timer.

Test Plan:
- Reset mid-run with RESET=0 pulse -> all outputs 0 immediately (async), LFSR=SEED after release.
- RATE=3, ENABLE=1, DENSITY=0 -> STEP every 4 clocks, first STEP 4 clocks after enable, SPAWN stays 0, NOTE_CNT=0.
- DENSITY=8, MIN_GAP=2, RATE=0 -> SPAWN pattern 1,0,0,1,0,0 per step; NOTE_CNT=10 after 30 steps; BUSY high during the two empty steps.
- DENSITY=8, 800 steps with MIN_GAP=2 -> NOTE_CNT saturates at 255, no wrap.
- ENABLE dropped during COOLDOWN -> SPAWN=0, BUSY=0 next cycle; re-enable with DENSITY=8 -> spawn on first STEP (gap not resumed).
- With COLUMN_SPAWNER_SEED_LOAD_EN: SEED_LOAD with SEED_VAL=0 in a STEP cycle -> LFSR=1, no spawn that step; identical SEED_VAL twice -> identical SPAWN sequences.
